// File: rtl/matmul_ctrl.sv
// Sequencer for a K-deep MAC array: clears the accumulators, streams K enabled beats,
// waits out the MAC pipeline, then holds the result until the consumer takes it.
module matmul_ctrl #(
  parameter int K       = 2,
  parameter int MAC_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 dp_clear,
  output logic                 dp_en,
  output logic [$clog2(K):0]   dp_k,
  output logic                 c_valid,
  input  logic                 c_ready,
  output logic                 done,
  output logic [CNT_W-1:0]     op_count
);

  localparam int KW = $clog2(K) + 1;
  localparam logic [KW-1:0] BEAT_LAST  = KW'(K - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    beat_q, beat_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_s;

  // State, beat/drain counters and completed-operation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= {KW{1'b0}};
      drain_q <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort takes priority over every forward transition
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        beat_d = {KW{1'b0}};
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_IDLE;
          beat_d  = {KW{1'b0}};
        end else if (beat_q == BEAT_LAST) begin
          beat_d  = {KW{1'b0}};
          drain_d = 4'd0;
          state_d = (MAC_LAT > 0) ? S_DRAIN : S_HOLD;
        end else begin
          beat_d  = beat_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          drain_d = 4'd0;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = S_HOLD;
          drain_d = 4'd0;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (c_ready) begin
          state_d = S_IDLE;
          done_s  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = {KW{1'b0}};
        drain_d = 4'd0;
      end
    endcase
  end

  // Outputs decode the registered state; done is the live handshake, masked while in reset
  assign busy     = (state_q != S_IDLE);
  assign dp_clear = (state_q == S_CLEAR);
  assign dp_en    = (state_q == S_ACCUM);
  assign dp_k     = (state_q == S_ACCUM) ? beat_q : {KW{1'b0}};
  assign c_valid  = (state_q == S_HOLD);
  assign done     = done_s & rst_n;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: two instances (K=2/LAT=1/CNT_W=2 and K=4/LAT=0),
// per-cycle expected outputs queued at drive time and compared mid-cycle.
module tb_matmul_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn_a, st_a, ab_a, rd_a;
  logic        busy_a, clr_a, en_a, cv_a, done_a;
  logic [1:0]  k_a;
  logic [1:0]  cnt_a;

  logic        rn_b, st_b, ab_b, rd_b;
  logic        busy_b, clr_b, en_b, cv_b, done_b;
  logic [2:0]  k_b;
  logic [15:0] cnt_b;

  matmul_ctrl #(.K(2), .MAC_LAT(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rn_a), .start(st_a), .abort(ab_a), .busy(busy_a),
    .dp_clear(clr_a), .dp_en(en_a), .dp_k(k_a), .c_valid(cv_a),
    .c_ready(rd_a), .done(done_a), .op_count(cnt_a)
  );

  matmul_ctrl #(.K(4), .MAC_LAT(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rn_b), .start(st_b), .abort(ab_b), .busy(busy_b),
    .dp_clear(clr_b), .dp_en(en_b), .dp_k(k_b), .c_valid(cv_b),
    .c_ready(rd_b), .done(done_b), .op_count(cnt_b)
  );

  typedef struct packed {
    logic        busy;
    logic        clr;
    logic        en;
    logic [2:0]  k;
    logic        cv;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  // One clock cycle: drive inputs after the edge, queue the expected outputs, compare mid-cycle.
  // ph: 0 IDLE, 1 CLEAR, 2 ACCUM, 3 DRAIN, 4 HOLD
  task automatic cyc(input bit sel, input logic st, input logic ab, input logic rd,
                     input logic rn, input int ph, input int kk, input int cnt);
    vec_t e;
    vec_t o;
    @(posedge clk);
    #1;
    if (sel == 1'b0) begin
      st_a = st; ab_a = ab; rd_a = rd; rn_a = rn;
    end else begin
      st_b = st; ab_b = ab; rd_b = rd; rn_b = rn;
    end
    e.busy = (ph != 0);
    e.clr  = (ph == 1);
    e.en   = (ph == 2);
    e.k    = 3'(kk);
    e.cv   = (ph == 4);
    e.done = (ph == 4) && rd && !ab && rn;
    e.cnt  = 16'(cnt);
    sb_q.push_back(e);
    @(negedge clk);
    if (sel == 1'b0) begin
      o = {busy_a, clr_a, en_a, 1'b0, k_a, cv_a, done_a, 14'd0, cnt_a};
    end else begin
      o = {busy_b, clr_b, en_b, k_b, cv_b, done_b, cnt_b};
    end
    e = sb_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL step%0d dut%0d observed={busy%b clr%b en%b k%0d cv%b done%b cnt%0d} expected={busy%b clr%b en%b k%0d cv%b done%b cnt%0d}",
             cyc_n, sel, o.busy, o.clr, o.en, o.k, o.cv, o.done, o.cnt,
             e.busy, e.clr, e.en, e.k, e.cv, e.done, e.cnt);
    end
    cyc_n++;
  endtask

  // Full operation with c_ready held high; the following IDLE cycle belongs to the caller
  task automatic run_op(input bit sel, input int kd, input int lat, input int cnt);
    cyc(sel, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, cnt);
    cyc(sel, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, cnt);
    for (int i = 0; i < kd; i++) cyc(sel, 1'b0, 1'b0, 1'b1, 1'b1, 2, i, cnt);
    for (int i = 0; i < lat; i++) cyc(sel, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0, cnt);
    cyc(sel, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, cnt);
  endtask

  initial begin
    rn_a = 1'b0; st_a = 1'b0; ab_a = 1'b0; rd_a = 1'b0;
    rn_b = 1'b0; st_b = 1'b0; ab_b = 1'b0; rd_b = 1'b0;

    // Reset state, then basic op: clear c1, beats c2-3, drain c4, hold+done c5, idle c6
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_op(0, 2, 1, 0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1);

    // Back-pressure: c_ready low until c9, start at c3 and c7 ignored
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 1);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 1);

    // Start in the first IDLE cycle after handshake, then abort during ACCUM
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 2);
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);

    // Abort and c_ready together in HOLD: abort wins
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 2);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);

    // Start with abort in IDLE stays IDLE; abort in CLEAR and in DRAIN
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 2);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 2);
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);

    // Reset mid-ACCUM at c3: everything zero from c4
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 2);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

    // Four back-to-back ops on the 2-bit counter: 1,2,3,0
    for (int i = 0; i < 4; i++) run_op(0, 2, 1, i % 4);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

    // K=4, MAC_LAT=0: beats c2-5, c_valid c6 with no drain, handshake at c7
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 2, i, 0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 0);
    cyc(1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 0);
    run_op(1, 4, 0, 1);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
